// File: rtl/robs_mult_seq.sv
// robs_mult_seq: sequential Robertson's multiplier with start/busy/done handshake
// and a per-operation signed/unsigned mode; the product is held until the next completion.
module robs_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [WIDTH-1:0]  a, x, y;
  logic [CW-1:0]     cnt;
  logic              mode;
  logic [WIDTH:0]    ea, ey, s;
  always_comb begin
    ea = {mode & a[WIDTH-1], a};
    ey = {mode & y[WIDTH-1], y};
    s  = x[0] ? ((mode && cnt == '0) ? ea - ey : ea + ey) : ea;
  end
  // done and product are registered out of DONE, so the pulse lands in the following IDLE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      x       <= '0;
      y       <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          a     <= '0;
          x     <= multiplier;
          y     <= multiplicand;
          mode  <= signed_mode;
          cnt   <= CW'(WIDTH - 1);
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a <= s[WIDTH:1];
          x <= {s[0], x[WIDTH-1:1]};
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= DONE;
          end else cnt <= cnt - 1'b1;
        end
        DONE: begin
          product <= {a, x};
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
